// File: rtl/lfsr_rand_arbiter.sv
`default_nettype none
// lfsr_rand_arbiter: round-robin sequencer time-sharing one external LFSR core among N_REQ requesters.
// Define LFSR_LOCKUP_GUARD_EN to reseed the core whenever it is observed in the all-ones lock-up state.
module lfsr_rand_arbiter #(
  parameter int          LFSR_BITS = 16,
  parameter int          OUT_BITS  = 8,
  parameter int          N_REQ     = 4,
  parameter int          STEPS     = OUT_BITS,
  parameter logic [31:0] SEED      = 32'h0000_ACE1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic [N_REQ-1:0]     i_Req,
  output logic [N_REQ-1:0]     o_Gnt,
  output logic                 o_Rand_Valid,
  output logic [OUT_BITS-1:0]  o_Rand_Data,
  output logic                 o_Busy,
  output logic                 o_Lfsr_Enable,
  output logic                 o_Lfsr_Seed_DV,
  output logic [LFSR_BITS-1:0] o_Lfsr_Seed_Data,
  input  logic [LFSR_BITS-1:0] i_Lfsr_Data
);

  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int PTR_W = $clog2(N_REQ);

  localparam logic [1:0] ST_SEED    = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_STEP    = 2'd2;
  localparam logic [1:0] ST_DELIVER = 2'd3;

  localparam logic [CNT_W-1:0]     CNT_INIT = CNT_W'(STEPS - 1);
  localparam logic [LFSR_BITS-1:0] SEED_VAL = SEED[LFSR_BITS-1:0];

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    win;
  logic [PTR_W-1:0]    pick;
  logic [OUT_BITS-1:0] rand_q;
  logic                lock_q;
  logic                found;
  int                  idx;

  // Round-robin search: first requester at or above ptr, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && i_Req[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state  <= ST_SEED;
      cnt    <= '0;
      ptr    <= '0;
      win    <= '0;
      rand_q <= '0;
    end else begin
      case (state)
        ST_SEED: state <= ST_IDLE;
        ST_IDLE: begin
          if (|i_Req) begin
            win   <= pick;
            cnt   <= CNT_INIT;
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (!i_Req[win])   state <= ST_IDLE;
          else if (cnt == '0) state <= ST_DELIVER;
          else               cnt   <= cnt - CNT_W'(1);
        end
        ST_DELIVER: begin
          rand_q <= i_Lfsr_Data[OUT_BITS-1:0];
          ptr    <= (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LFSR_LOCKUP_GUARD_EN
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) lock_q <= 1'b0;
    else          lock_q <= ((state == ST_IDLE) || (state == ST_STEP)) && (&i_Lfsr_Data);
  end
`else
  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^i_Lfsr_Data;
  assign lock_q           = 1'b0;
`endif

  // State resets to SEED, so the strobes are gated by reset to keep outputs low while held.
  assign o_Busy           = i_Rst_L & (state != ST_IDLE);
  assign o_Lfsr_Enable    = i_Rst_L & ((state != ST_DELIVER) | lock_q);
  assign o_Lfsr_Seed_DV   = i_Rst_L & ((state == ST_SEED) | lock_q);
  assign o_Lfsr_Seed_Data = i_Rst_L ? SEED_VAL : '0;
  assign o_Rand_Valid     = (state == ST_DELIVER);
  assign o_Gnt            = (state == ST_DELIVER) ? (N_REQ'(1) << win) : '0;
  assign o_Rand_Data      = (state == ST_DELIVER) ? i_Lfsr_Data[OUT_BITS-1:0] : rand_q;

endmodule
`default_nettype wire
